// File: rtl/depuncturer_if.sv
// -----------------------------------------------------------------------------
// depuncturer_if
//
// Bundles the two AXI-Stream style channels around the depuncturer:
//   s_axis_* : serial received coded soft bits, one per beat, with rate code
//              on tuser and end-of-packet on tlast.
//   m_axis_* : restored rate-1/2 pairs {g1,g0}, per-element erase flags,
//              latched packet rate and end-of-packet marker.
//
// Modports:
//   slave  : the depuncturer's view (consumes s_axis_*, produces m_axis_*).
//   master : the surrounding environment's view (produces s_axis_*, consumes
//            m_axis_*).
// -----------------------------------------------------------------------------
interface depuncturer_if #(
  parameter int SOFT_W = 4
);
  logic [SOFT_W-1:0]   s_axis_tdata;
  logic [3:0]          s_axis_tuser;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                s_axis_tlast;

  logic [2*SOFT_W-1:0] m_axis_tdata;
  logic [1:0]          m_axis_terase;
  logic [3:0]          m_axis_tuser;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tuser,
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tlast,
    output m_axis_tdata,
    output m_axis_terase,
    output m_axis_tuser,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tuser,
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tlast,
    input  m_axis_tdata,
    input  m_axis_terase,
    input  m_axis_tuser,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );
endinterface

// File: rtl/depuncturer.sv
// -----------------------------------------------------------------------------
// depuncturer
//
// Receive-side inverse of the transmit puncturing stage. Takes one received
// coded soft bit per beat and rebuilds the rate-1/2 {g0,g1} pair stream for
// the Viterbi decoder, inserting ERASE_VAL at punctured positions and flagging
// every inserted element on m_axis_terase.
//
// Ports:
//   aclk          clock
//   aresetn       synchronous, active-low reset
//   dp_io         depuncturer_if.slave
//                   s_axis_tdata  [SOFT_W-1:0]   received soft bit
//                   s_axis_tuser  [3:0]          rate code (sampled on first beat)
//                   s_axis_tvalid/tready/tlast   input handshake, end of packet
//                   m_axis_tdata  [2*SOFT_W-1:0] {g1,g0}
//                   m_axis_terase [1:0]          bit0 = g0 inserted, bit1 = g1 inserted
//                   m_axis_tuser  [3:0]          latched packet rate
//                   m_axis_tvalid/tready/tlast   output handshake, last pair
//   rate_err      (only with DEPUNCTURER_RATE_CHECK_EN) sticky flag: a later
//                 beat of a packet carried a rate code different from the
//                 one latched on its first beat.
//
// Optional feature macro: DEPUNCTURER_RATE_CHECK_EN
// -----------------------------------------------------------------------------

// 802.11a SIGNAL-field RATE encodings; guarded so a shared definitions file
// compiled earlier takes precedence.
`ifndef RATE_6M
  `define RATE_6M  4'b1011
`endif
`ifndef RATE_9M
  `define RATE_9M  4'b1111
`endif
`ifndef RATE_12M
  `define RATE_12M 4'b1010
`endif
`ifndef RATE_18M
  `define RATE_18M 4'b1110
`endif
`ifndef RATE_24M
  `define RATE_24M 4'b1001
`endif
`ifndef RATE_36M
  `define RATE_36M 4'b1101
`endif
`ifndef RATE_48M
  `define RATE_48M 4'b1000
`endif
`ifndef RATE_54M
  `define RATE_54M 4'b1100
`endif

module depuncturer #(
  parameter int SOFT_W    = 4,
  parameter int ERASE_VAL = 0
) (
  input  logic         aclk,
  input  logic         aresetn,
  depuncturer_if.slave dp_io
`ifdef DEPUNCTURER_RATE_CHECK_EN
  ,
  output logic         rate_err
`endif
);

  localparam logic [SOFT_W-1:0] ERASE_METRIC = SOFT_W'(ERASE_VAL);

  typedef enum logic [1:0] {
    CLS_1_2,
    CLS_2_3,
    CLS_3_4
  } punct_cls_e;

  // What the accepted bit does to the pair under assembly.
  typedef enum logic [1:0] {
    ROLE_HOLD,     // g0 whose g1 is also received: park it in the hold register
    ROLE_G1,       // g1 that completes a pair with the held g0
    ROLE_G0_ONLY,  // g0 whose g1 was punctured: pair completes now
    ROLE_G1_ONLY   // g1 whose g0 was punctured: pair completes now
  } role_e;

  function automatic punct_cls_e rate_class(input logic [3:0] rate);
    punct_cls_e cls;
    unique case (rate)
      `RATE_9M, `RATE_18M, `RATE_36M, `RATE_54M: cls = CLS_3_4;
      `RATE_48M:                                  cls = CLS_2_3;
      default:                                    cls = CLS_1_2;
    endcase
    return cls;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          phase_q,     phase_d;
  logic                pkt_start_q, pkt_start_d;
  logic [3:0]          rate_q,      rate_d;
  logic [SOFT_W-1:0]   hold_q,      hold_d;

  logic [2*SOFT_W-1:0] m_data_q,    m_data_d;
  logic [1:0]          m_erase_q,   m_erase_d;
  logic [3:0]          m_user_q,    m_user_d;
  logic                m_last_q,    m_last_d;
  logic                m_valid_q,   m_valid_d;

  // ---------------------------------------------------------------------------
  // Beat classification
  // ---------------------------------------------------------------------------
  logic [3:0] cur_rate;
  punct_cls_e cls;
  role_e      role;
  logic [1:0] last_phase;
  logic       hold_only;
  logic       s_ready;
  logic       s_hs;
  logic       m_hs;

  // The first beat of a packet is classified with its own tuser, since the
  // latch only captures it on that same handshake.
  assign cur_rate = pkt_start_q ? dp_io.s_axis_tuser : rate_q;
  assign cls      = rate_class(cur_rate);

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    role       = ROLE_HOLD;
    last_phase = 2'd1;
    unique case (cls)
      CLS_1_2: begin
        last_phase = 2'd1;
        role       = (phase_q == 2'd0) ? ROLE_HOLD : ROLE_G1;
      end
      CLS_2_3: begin
        last_phase = 2'd2;
        unique case (phase_q)
          2'd0:    role = ROLE_HOLD;
          2'd1:    role = ROLE_G1;
          default: role = ROLE_G0_ONLY;
        endcase
      end
      CLS_3_4: begin
        last_phase = 2'd3;
        unique case (phase_q)
          2'd0:    role = ROLE_HOLD;
          2'd1:    role = ROLE_G1;
          2'd2:    role = ROLE_G0_ONLY;
          default: role = ROLE_G1_ONLY;
        endcase
      end
      default: begin
        last_phase = 2'd1;
        role       = ROLE_HOLD;
      end
    endcase
  end

  // A g0 that ends the packet cannot wait for its partner, so it completes.
  assign hold_only = (role == ROLE_HOLD) && !dp_io.s_axis_tlast;

  // Filling the hold register never needs output space; completing does.
  assign s_ready = hold_only || !m_valid_q || dp_io.m_axis_tready;
  assign s_hs    = dp_io.s_axis_tvalid && s_ready;
  assign m_hs    = m_valid_q && dp_io.m_axis_tready;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d     = phase_q;
    pkt_start_d = pkt_start_q;
    rate_d      = rate_q;
    hold_d      = hold_q;
    m_data_d    = m_data_q;
    m_erase_d   = m_erase_q;
    m_user_d    = m_user_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;

    // A completion in the same cycle overrides this clear below.
    if (m_hs) begin
      m_valid_d = 1'b0;
    end

    if (s_hs) begin
      if (pkt_start_q) begin
        rate_d = dp_io.s_axis_tuser;
      end
      pkt_start_d = dp_io.s_axis_tlast;

      if (dp_io.s_axis_tlast || (phase_q == last_phase)) begin
        phase_d = 2'd0;
      end else begin
        phase_d = phase_q + 2'd1;
      end

      if (hold_only) begin
        hold_d = dp_io.s_axis_tdata;
      end else begin
        m_valid_d = 1'b1;
        m_user_d  = cur_rate;
        m_last_d  = dp_io.s_axis_tlast;
        unique case (role)
          ROLE_G1: begin
            m_data_d  = {dp_io.s_axis_tdata, hold_q};
            m_erase_d = 2'b00;
          end
          ROLE_G1_ONLY: begin
            m_data_d  = {dp_io.s_axis_tdata, ERASE_METRIC};
            m_erase_d = 2'b01;
          end
          // ROLE_HOLD reaches here only when tlast forces the pair out early.
          default: begin
            m_data_d  = {ERASE_METRIC, dp_io.s_axis_tdata};
            m_erase_d = 2'b10;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      phase_q     <= 2'd0;
      pkt_start_q <= 1'b1;
      rate_q      <= 4'd0;
      // NOTE: the hold register is only read after a write, but it is still
      // cleared so a discarded partial pair leaves no trace after reset.
      hold_q      <= '0;
      m_data_q    <= '0;
      m_erase_q   <= 2'b00;
      m_user_q    <= 4'd0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      pkt_start_q <= pkt_start_d;
      rate_q      <= rate_d;
      hold_q      <= hold_d;
      m_data_q    <= m_data_d;
      m_erase_q   <= m_erase_d;
      m_user_q    <= m_user_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign dp_io.s_axis_tready = s_ready;
  assign dp_io.m_axis_tdata  = m_data_q;
  assign dp_io.m_axis_terase = m_erase_q;
  assign dp_io.m_axis_tuser  = m_user_q;
  assign dp_io.m_axis_tlast  = m_last_q;
  assign dp_io.m_axis_tvalid = m_valid_q;

`ifdef DEPUNCTURER_RATE_CHECK_EN
  // ---------------------------------------------------------------------------
  // Sticky mid-packet rate mismatch flag
  // ---------------------------------------------------------------------------
  logic rate_err_q, rate_err_d;

  always_comb begin
    rate_err_d = rate_err_q;
    if (s_hs && !pkt_start_q && (dp_io.s_axis_tuser != rate_q)) begin
      rate_err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rate_err_q <= 1'b0;
    end else begin
      rate_err_q <= rate_err_d;
    end
  end

  assign rate_err = rate_err_q;
`endif

endmodule
